mac_norm_scheduler: RTL and testbench

MAC_NORM_SCHEDULER -- requirements
Module: mac_norm_scheduler

---
 rtl/mac_norm_pkg.sv | 40 ++++
 rtl/mac_rr_arbiter.sv | 51 +++++
 rtl/mac_norm_scheduler.sv | 179 +++++++++++++++++
 tb/tb_mac_norm_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_norm_pkg.sv
// mac_norm_pkg: shared constants and stage payload types for the MAC
// normalizer scheduler (accumulator sum -> half-precision result).
package mac_norm_pkg;

    localparam int SUM_W     = 19;  // two's-complement accumulator sum
    localparam int EXP_W     = 5;   // biased base exponent
    localparam int SIG_W     = 11;  // significand incl. hidden one
    localparam int EXP_BIAS  = 15;
    localparam int EXP_MAX   = 30;  // largest finite biased exponent
    localparam int FRAC_BITS = 13;  // binary point sits below sum bit 13
    localparam int LANE_W    = 2;
    localparam int RES_W     = 16;
    localparam int FLG_W     = 3;

    // o_flags bit positions: {overflow, underflow, zero}
    localparam int FLG_OVF   = 2;
    localparam int FLG_UNF   = 1;
    localparam int FLG_ZERO  = 0;

    // Stage 1 payload: the accepted request as captured from its lane
    typedef struct packed {
        logic [LANE_W-1:0] lane;
        logic [SUM_W-1:0]  sum;
        logic [EXP_W-1:0]  exp;
    } stage_t;

    // Leading-one/shift result, input to rounding and exponent adjust
    typedef struct packed {
        logic [LANE_W-1:0] lane;
        logic              sign;
        logic              force_ovf;  // sum is the most negative value
        logic              is_zero;    // no leading one in bits 17..3
        logic [SIG_W-1:0]  sig;
        logic              grd;
        logic              rnd;
        logic              stk;
        logic signed [6:0] exp_pre;    // exp + exp_diff, before carry
    } norm_t;

endpackage

// File: rtl/mac_rr_arbiter.sv
// mac_rr_arbiter: round-robin grant among NUM_LANES requesters. The pointer
// moves to the lane after the one granted; grant is suppressed while the
// consumer cannot take a request or reset is asserted.
module mac_rr_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int IDX_W     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_LANES-1:0] i_req,
    input  logic                 i_en,
    output logic [NUM_LANES-1:0] o_grant,
    output logic [IDX_W-1:0]     o_grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic             found;

    // Search from the pointer, wrapping, for the first requesting lane
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int off = 0; off < NUM_LANES; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            if (!found && i_req[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    // One-hot grant only when the downstream stage can load
    always_comb begin
        o_grant = '0;
        if (found && i_en && !i_rst) o_grant[win] = 1'b1;
        o_grant_idx = win;
    end

    // Pointer advances past the granted lane on every transfer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            ptr <= '0;
        else if (|o_grant)
            ptr <= (win == IDX_W'(NUM_LANES-1)) ? '0 : win + 1'b1;
    end

endmodule

// File: rtl/mac_norm_scheduler.sv
// mac_norm_scheduler: NUM_LANES accumulator lanes share one normalizer that
// turns a fixed-point sum plus base exponent into an fp16 result.
// Define NORM_PIPE_EN to register between leading-one/shift and
// round/exponent-adjust (latency 3 instead of 2, same results).
module mac_norm_scheduler
    import mac_norm_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_LANES-1:0]            i_req_valid,
    output logic [NUM_LANES-1:0]            o_req_ready,
    input  logic [NUM_LANES-1:0][SUM_W-1:0] i_sum,
    input  logic [NUM_LANES-1:0][EXP_W-1:0] i_exp,
    input  logic                            i_ready,
    output logic                            o_valid,
    output logic [LANE_W-1:0]               o_lane,
    output logic [RES_W-1:0]                o_result,
    output logic [FLG_W-1:0]                o_flags,
    output logic [7:0]                      o_ovf_cnt
);

`ifdef NORM_PIPE_EN
    localparam int STAGES = 3;
`else
    localparam int STAGES = 2;
`endif

    localparam logic signed [6:0] EXP_MAX_S = 7'(EXP_MAX);

    logic [STAGES:1]   vld_pipe;
    logic              out_en;
    logic              s1_en;
    logic              acc;
    logic [LANE_W-1:0] gnt_idx;
    stage_t            s1;
    norm_t             nrm_d;
    norm_t             rin;

    logic [17:0]       mag;
    logic [17:0]       norm;
    logic [4:0]        lz_pos;
    logic              lz_found;
    logic              rnd_up;
    logic [SIG_W:0]    sig_r;
    logic signed [6:0] exp_new;
    logic [RES_W-1:0]  res;
    logic [FLG_W-1:0]  flg;

    // Each stage may load when it is empty or its contents move on
    assign out_en  = ~vld_pipe[STAGES] | i_ready;
`ifdef NORM_PIPE_EN
    logic mid_en;
    assign mid_en  = ~vld_pipe[2] | out_en;
    assign s1_en   = ~vld_pipe[1] | mid_en;
`else
    assign s1_en   = ~vld_pipe[1] | out_en;
`endif
    assign o_valid = vld_pipe[STAGES];
    assign acc     = |o_req_ready;

    mac_rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (LANE_W)
    ) u_arb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req_valid),
        .i_en        (s1_en),
        .o_grant     (o_req_ready),
        .o_grant_idx (gnt_idx)
    );

    // Stage valids shift forward, each gated by its own enable
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_pipe <= '0;
        end else begin
            if (s1_en) vld_pipe[1] <= acc;
`ifdef NORM_PIPE_EN
            if (mid_en) vld_pipe[2] <= vld_pipe[1];
`endif
            if (out_en) vld_pipe[STAGES] <= vld_pipe[STAGES-1];
        end
    end

    // Stage 1: capture the granted lane's request
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            s1 <= '0;
        else if (s1_en && acc)
            s1 <= '{lane: gnt_idx, sum: i_sum[gnt_idx], exp: i_exp[gnt_idx]};
    end

    // Magnitude, leading one in 17..3, and left-justify to bit 17
    always_comb begin
        mag      = s1.sum[SUM_W-1] ? (~s1.sum[17:0] + 18'd1) : s1.sum[17:0];
        lz_pos   = '0;
        lz_found = 1'b0;
        for (int b = 3; b <= 17; b++) begin
            if (mag[b]) begin
                lz_pos   = 5'(b);
                lz_found = 1'b1;
            end
        end
        norm             = mag << (5'd17 - lz_pos);
        nrm_d.lane       = s1.lane;
        nrm_d.sign       = s1.sum[SUM_W-1];
        nrm_d.force_ovf  = (s1.sum == 19'h40000);
        nrm_d.is_zero    = ~lz_found;
        nrm_d.sig        = norm[17:7];
        nrm_d.grd        = norm[6];
        nrm_d.rnd        = norm[5];
        nrm_d.stk        = |norm[4:0];
        nrm_d.exp_pre    = 7'(s1.exp) + 7'(lz_pos) - 7'(FRAC_BITS);
    end

`ifdef NORM_PIPE_EN
    norm_t nrm_q;

    // Optional register between shift and rounding
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            nrm_q <= '0;
        else if (mid_en && vld_pipe[1])
            nrm_q <= nrm_d;
    end
    assign rin = nrm_q;
`else
    assign rin = nrm_d;
`endif

    // Round to nearest even, fold carry into exponent, classify result
    always_comb begin
        rnd_up  = rin.grd & (rin.rnd | rin.stk | rin.sig[0]);
        sig_r   = {1'b0, rin.sig} + (SIG_W+1)'(rnd_up);
        // carry-out leaves 1.000..0 after the right shift, so frac is zero
        exp_new = rin.exp_pre + $signed({6'b0, sig_r[SIG_W]});
        res     = '0;
        flg     = '0;
        if (rin.force_ovf) begin
            res          = {rin.sign, 5'h1F, 10'h0};
            flg[FLG_OVF] = 1'b1;
        end else if (rin.is_zero) begin
            flg[FLG_ZERO] = 1'b1;
        end else if (exp_new > EXP_MAX_S) begin
            res          = {rin.sign, 5'h1F, 10'h0};
            flg[FLG_OVF] = 1'b1;
        end else if (exp_new <= 7'sd0) begin
            res          = {rin.sign, 15'h0};
            flg[FLG_UNF] = 1'b1;
        end else begin
            res = {rin.sign, exp_new[4:0], sig_r[SIG_W] ? 10'h0 : sig_r[9:0]};
        end
    end

    // Output stage: holds while the downstream stalls
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_lane   <= '0;
            o_result <= '0;
            o_flags  <= '0;
        end else if (out_en && vld_pipe[STAGES-1]) begin
            o_lane   <= rin.lane;
            o_result <= res;
            o_flags  <= flg;
        end
    end

    // Count delivered overflow results, saturating
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_ovf_cnt <= '0;
        else if (o_valid && i_ready && o_flags[FLG_OVF] && o_ovf_cnt != 8'hFF)
            o_ovf_cnt <= o_ovf_cnt + 8'd1;
    end

endmodule

// File: tb/tb_mac_norm_scheduler.sv
// Directed bench for mac_norm_scheduler (NUM_LANES=4); expected results are
// hand-computed fp16 encodings.
module tb_mac_norm_scheduler;

    localparam int NL = 4;
`ifdef NORM_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int NT = 20;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic [NL-1:0]        i_req_valid;
    logic [NL-1:0]        o_req_ready;
    logic [NL-1:0][18:0]  i_sum;
    logic [NL-1:0][4:0]   i_exp;
    logic                 i_ready;
    logic                 o_valid;
    logic [1:0]           o_lane;
    logic [15:0]          o_result;
    logic [2:0]           o_flags;
    logic [7:0]           o_ovf_cnt;

    int checks = 0;
    int errors = 0;

    // table: sum, exp -> result, {ovf, unf, zero}
    logic [18:0] t_sum [NT] = '{19'h02000, 19'h7E000, 19'h20000, 19'h00000,
                                19'h3FFFF, 19'h20040, 19'h200C0, 19'h00008,
                                19'h7FFF8, 19'h40000, 19'h00018, 19'h02000,
                                19'h02000, 19'h02000, 19'h02000, 19'h00004,
                                19'h20041, 19'h5FFC0, 19'h10000, 19'h3FFFF};
    logic [4:0]  t_exp [NT] = '{5'd15, 5'd15, 5'd28, 5'd15,
                                5'd15, 5'd15, 5'd15, 5'd5,
                                5'd5,  5'd15, 5'd15, 5'd30,
                                5'd31, 5'd1,  5'd0,  5'd15,
                                5'd15, 5'd15, 5'd15, 5'd26};
    logic [15:0] t_res [NT] = '{16'h3C00, 16'hBC00, 16'h7C00, 16'h0000,
                                16'h5000, 16'h4C00, 16'h4C02, 16'h0000,
                                16'h8000, 16'hFC00, 16'h1A00, 16'h7800,
                                16'h7C00, 16'h0400, 16'h0000, 16'h0000,
                                16'h4C01, 16'hCC00, 16'h4800, 16'h7C00};
    logic [2:0]  t_flg [NT] = '{3'b000, 3'b000, 3'b100, 3'b001,
                                3'b000, 3'b000, 3'b000, 3'b010,
                                3'b010, 3'b100, 3'b000, 3'b000,
                                3'b100, 3'b000, 3'b010, 3'b001,
                                3'b000, 3'b000, 3'b000, 3'b100};
    logic [15:0] burst_res [4] = '{16'h3C00, 16'h4000, 16'h4400, 16'h4800};
    logic [15:0] stall_res [3] = '{16'h3C00, 16'hC000, 16'h4400};

    always #5 i_clk = ~i_clk;

    mac_norm_scheduler #(.NUM_LANES(NL)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_sum       (i_sum),
        .i_exp       (i_exp),
        .i_ready     (i_ready),
        .o_valid     (o_valid),
        .o_lane      (o_lane),
        .o_result    (o_result),
        .o_flags     (o_flags),
        .o_ovf_cnt   (o_ovf_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          ln, c, exp_cnt, got_n, acc_n;
        logic [3:0]  rdy;
        logic [1:0]  got_lane [4];
        logic [15:0] got_res [4];
        int          got_cyc [4];

        i_rst = 1'b0; i_req_valid = '0; i_ready = 1'b1; i_sum = '0; i_exp = '0;
        #2 i_rst = 1'b1;
        #1;
        chk("rst_valid",  o_valid,     0);
        chk("rst_ready",  o_req_ready, 0);
        chk("rst_lane",   o_lane,      0);
        chk("rst_result", o_result,    0);
        chk("rst_flags",  o_flags,     0);
        chk("rst_ovfcnt", o_ovf_cnt,   0);
        @(negedge i_clk); @(negedge i_clk);
        i_rst = 1'b0;

        // single requests, one per lane in turn
        exp_cnt = 0;
        for (int i = 0; i < NT; i++) begin
            ln = i % 4;
            i_sum[ln] = t_sum[i];
            i_exp[ln] = t_exp[i];
            i_req_valid = 4'(1 << ln);
            #1;
            chk($sformatf("t%0d_ready", i), o_req_ready, 32'(1 << ln));
            @(posedge i_clk); @(negedge i_clk);
            i_req_valid = '0;
            c = 1;
            while (!o_valid && c < 10) begin
                @(negedge i_clk);
                c++;
            end
            chk($sformatf("t%0d_latency", i), c, LAT);
            chk($sformatf("t%0d_lane", i), o_lane, ln);
            chk($sformatf("t%0d_result", i), o_result, t_res[i]);
            chk($sformatf("t%0d_flags", i), o_flags, t_flg[i]);
            if (t_flg[i][2]) exp_cnt++;
            @(negedge i_clk);
            chk($sformatf("t%0d_ovfcnt", i), o_ovf_cnt, exp_cnt);
            chk($sformatf("t%0d_nodup", i), o_valid, 0);
        end

        // all lanes at once: grants 0..3, outputs back-to-back
        for (int k = 0; k < 4; k++) begin
            i_sum[k] = 19'h02000;
            i_exp[k] = 5'(15 + k);
        end
        i_req_valid = 4'hF;
        got_n = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (cyc < 5) chk($sformatf("burst_ready%0d", cyc), o_req_ready, (cyc < 4) ? (1 << cyc) : 0);
            rdy = o_req_ready;
            @(posedge i_clk); @(negedge i_clk);
            i_req_valid = i_req_valid & ~rdy;
            if (o_valid && got_n < 4) begin
                got_lane[got_n] = o_lane;
                got_res[got_n]  = o_result;
                got_cyc[got_n]  = cyc;
                got_n++;
            end
        end
        chk("burst_count", got_n, 4);
        for (int j = 0; j < got_n; j++) begin
            chk($sformatf("burst_lane%0d", j), got_lane[j], j);
            chk($sformatf("burst_res%0d", j), got_res[j], burst_res[j]);
            chk($sformatf("burst_cyc%0d", j), got_cyc[j], LAT - 1 + j);
        end

        // back-pressure: lanes 0,1 (plus lane 2 as an extra waiting requester)
        i_sum[0] = 19'h02000; i_exp[0] = 5'd15;
        i_sum[1] = 19'h7E000; i_exp[1] = 5'd16;
        i_sum[2] = 19'h02000; i_exp[2] = 5'd17;
        i_ready = 1'b0;
        i_req_valid = 4'b0111;
        acc_n = 0;
        for (int cyc = 0; cyc < LAT + 5; cyc++) begin
            #1;
            chk($sformatf("stall_ready%0d", cyc), o_req_ready, (acc_n < LAT) ? (1 << acc_n) : 0);
            rdy = o_req_ready;
            @(posedge i_clk); @(negedge i_clk);
            i_req_valid = i_req_valid & ~rdy;
            if (rdy != 0) acc_n++;
            if (cyc >= LAT - 1) begin
                chk($sformatf("stall_valid%0d", cyc), o_valid, 1);
                chk($sformatf("stall_res%0d", cyc), o_result, 16'h3C00);
                chk($sformatf("stall_lane%0d", cyc), o_lane, 0);
            end
        end
        i_ready = 1'b1;
        got_n = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            rdy = o_req_ready;
            if (o_valid && got_n < 3) begin
                got_lane[got_n] = o_lane;
                got_res[got_n]  = o_result;
                got_n++;
            end
            @(posedge i_clk); @(negedge i_clk);
            i_req_valid = i_req_valid & ~rdy;
        end
        chk("release_count", got_n, 3);
        for (int j = 0; j < got_n; j++) begin
            chk($sformatf("release_lane%0d", j), got_lane[j], j);
            chk($sformatf("release_res%0d", j), got_res[j], stall_res[j]);
        end

        // reset with a result on the output
        i_sum[1] = 19'h02000; i_exp[1] = 5'd15;
        i_req_valid = 4'b0010;
        #1;
        @(posedge i_clk); @(negedge i_clk);
        i_req_valid = '0;
        c = 1;
        while (!o_valid && c < 10) begin
            @(negedge i_clk);
            c++;
        end
        chk("prerst_valid", o_valid, 1);
        chk("prerst_lane", o_lane, 1);
        #2;
        i_req_valid = 4'hF;
        i_rst = 1'b1;
        #1;
        chk("midrst_valid",  o_valid,     0);
        chk("midrst_ready",  o_req_ready, 0);
        chk("midrst_lane",   o_lane,      0);
        chk("midrst_result", o_result,    0);
        chk("midrst_flags",  o_flags,     0);
        chk("midrst_ovfcnt", o_ovf_cnt,   0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("postrst_ptr", o_req_ready, 4'b0001);
        i_req_valid = '0;
        for (int cyc = 0; cyc < LAT + 2; cyc++) begin
            @(negedge i_clk);
            chk($sformatf("postrst_idle%0d", cyc), o_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
